// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: controller state encoding.
package serial_sub_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two half subtractors and an OR on the borrows.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (
        .x (x),
        .y (y),
        .d (d1),
        .b (b1)
    );

    half_subtractor u_hs1 (
        .x (d1),
        .y (bi),
        .d (d),
        .b (b2)
    );

    assign bo = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// One-bit half subtractor: d = x - y, b = borrow out.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);

    assign d = x ^ y;
    assign b = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell with a registered borrow.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_bit;
    logic               cell_d;
    logic               cell_bo;
    logic [WIDTH-1:0]   a_sh_next;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
    // Result bits are shifted into the MSB vacated by the minuend, so after
    // WIDTH shifts the minuend register holds the complete difference.
    assign a_sh_next = {cell_d, a_sh[WIDTH-1:1]};

    full_subtractor u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (borrow),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh_next;
            b_sh   <= b_sh >> 1;
            borrow <= cell_bo;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                diff <= a_sh_next;
                bout <= cell_bo;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // On the final bit the cell inputs are the operand MSBs and cell_d is the result MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            ovf <= (a_sh[0] ^ b_sh[0]) & (cell_d ^ a_sh[0]);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, random ops against a
// plain-arithmetic model, back-to-back and mid-run reset sequences.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed integer arithmetic, borrow from the sign of the full result.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin,
                         output logic [WIDTH-1:0] ed, output logic eb, output logic eo);
        int r;
        r  = int'(ma) - int'(mb) - int'(mbin);
        ed = r[WIDTH-1:0];
        eb = (r < 0);
        eo = (ma[WIDTH-1] != mb[WIDTH-1]) && (ed[WIDTH-1] != ma[WIDTH-1]);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic op_bin, input bit scramble,
                          input logic [WIDTH-1:0] exp_diff, input logic exp_bout,
                          input logic exp_ovf);
        int k;
        int done_k;
        int busy_cnt;
        int overlap;
        k = 0; done_k = -1; busy_cnt = 0; overlap = 0;
        @(negedge clk);
        a = op_a; b = op_b; bin = op_bin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (done_k < 0 && k < 3 * WIDTH) begin
            @(negedge clk);
            k++;
            if (busy && done) overlap++;
            if (done) done_k = k;
            else if (busy) busy_cnt++;
            if (scramble && !done) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom);
                bin = 1'($urandom); start = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        check("done_latency", done_k, WIDTH + 1);
        check("busy_cycles", busy_cnt, WIDTH);
        check("busy_done_overlap", overlap, 0);
        check("diff", diff, exp_diff);
        check("bout", bout, exp_bout);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) check("ovf_unused", 0, 1);
`endif
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb, ed;
        logic             rbin, eb, eo;
        int               k, j, n;
        bit               seen;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset held with random inputs
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (4) begin
            @(negedge clk);
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            bin = 1'($urandom); start = 1'($urandom);
        end
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 8'h00);
        check("rst_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, bit'(i % 2),
                   vecs[i].diff, vecs[i].bout, vecs[i].ovf);

        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom);
            model(ra, rb, rbin, ed, eb, eo);
            run_op(ra, rb, rbin, bit'($urandom_range(0, 1)), ed, eb, eo);
        end

        // Back-to-back: start asserted during the DONE cycle
        @(negedge clk);
        a = 8'h5A; b = 8'h33; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (!done && k < 3 * WIDTH) begin
            @(negedge clk);
            k++;
        end
        check("b2b_first_diff", diff, 8'h27);
        a = 8'hC3; b = 8'h3C; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
        j = 0; seen = 0;
        while (!seen && j < 3 * WIDTH) begin
            @(negedge clk);
            j++;
            if (j == 1) check("b2b_busy_immediate", busy, 1'b1);
            if (done) seen = 1;
        end
        check("b2b_done_spacing", j, WIDTH + 1);
        check("b2b_second_diff", diff, 8'h86);
        check("b2b_second_bout", bout, 1'b0);

        // Asynchronous reset at RUN bit 4
        @(negedge clk);
        a = 8'h40; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_diff", diff, 8'h00);
        check("midrst_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("midrst_ovf", ovf, 1'b0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (2 * WIDTH) begin
            @(negedge clk);
            if (done) n++;
        end
        check("midrst_no_done", n, 0);
        run_op(8'h40, 8'h11, 1'b0, 1'b0, 8'h2F, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
